fifo_rd_stream: RTL

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

---
 rtl/fifo_rd_stream.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - read-side pointer logic and 2-entry skid buffer for an async FIFO
//
// Purpose: owns the read pointer of a dual-clock FIFO, synchronizes the
// write pointer into rclk, issues memory reads and turns the one-cycle
// memory latency into a gap-free valid/ready output stream.
//
// Ports:
//   rclk       read-domain clock
//   rrst_n     asynchronous active-low reset
//   g_wptr     Gray write pointer from the write domain (asynchronous)
//   r_en       read strobe to the FIFO memory
//   b_rptr     binary read pointer; low PTR_WIDTH bits address the memory
//   g_rptr     registered Gray read pointer for the write domain
//   mem_rdata  memory read data, valid the cycle after r_en
//   empty      FIFO empty as seen from the read side
//   level      read-side occupancy, 0..DEPTH
//   m_data     output stream data
//   m_valid    output stream valid
//   m_ready    output stream ready

module fifo_rd_stream #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8,
    parameter int PTR_WIDTH  = 3
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic [PTR_WIDTH:0]    g_wptr,
    output logic                  r_en,
    output logic [PTR_WIDTH:0]    b_rptr,
    output logic [PTR_WIDTH:0]    g_rptr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  empty,
    output logic [PTR_WIDTH:0]    level,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready
);

    if (DEPTH != (1 << PTR_WIDTH)) begin : g_depth_check
        $error("fifo_rd_stream: DEPTH must equal 2**PTR_WIDTH");
    end

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

    function automatic logic [PTR_WIDTH:0] bin2gray(input logic [PTR_WIDTH:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PTR_WIDTH:0] gray2bin(input logic [PTR_WIDTH:0] g);
        logic [PTR_WIDTH:0] b;
        b[PTR_WIDTH] = g[PTR_WIDTH];
        for (int i = PTR_WIDTH - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PTR_WIDTH:0]    g_wptr_q1;
    logic [PTR_WIDTH:0]    g_wptr_s;
    logic [PTR_WIDTH:0]    b_wptr_s;
    logic [PTR_WIDTH:0]    b_rptr_next;
    logic [PTR_WIDTH:0]    g_rptr_next;
    logic                  inflight;
    logic                  pop;
    logic [1:0]            occ;
    logic [1:0]            occ_next;
    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH-1:0] tail_q;

    // Two-flop synchronizer; g_wptr is never looked at directly.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            g_wptr_q1 <= '0;
            g_wptr_s  <= '0;
        end else begin
            g_wptr_q1 <= g_wptr;
            g_wptr_s  <= g_wptr_q1;
        end
    end

    assign b_wptr_s    = gray2bin(g_wptr_s);
    assign b_rptr_next = b_rptr + {{PTR_WIDTH{1'b0}}, r_en};
    assign g_rptr_next = bin2gray(b_rptr_next);

    assign pop = m_valid & m_ready;

    // Count the word already on its way from memory, so the buffer can never
    // be asked to hold a third word. A pop this cycle frees a slot in time.
    assign r_en = !empty && ((3'(occ) + 3'(inflight)) < (3'd2 + 3'(pop)));

    // empty/level are evaluated against the pointer after this cycle's read,
    // so a read can never be issued past the synchronized write pointer.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            b_rptr   <= '0;
            g_rptr   <= '0;
            empty    <= 1'b1;
            level    <= '0;
            inflight <= 1'b0;
        end else begin
            b_rptr   <= b_rptr_next;
            g_rptr   <= g_rptr_next;
            empty    <= (g_rptr_next == g_wptr_s);
            level    <= b_wptr_s - b_rptr_next;
            inflight <= r_en;
        end
    end

    // Output buffer occupancy: state register
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            occ <= OCC_EMPTY;
        end else begin
            occ <= occ_next;
        end
    end

    // Output buffer occupancy: next state (write = word arriving from memory)
    always_comb begin
        occ_next = occ;
        case (occ)
            OCC_EMPTY: if (inflight)         occ_next = OCC_ONE;
            OCC_ONE: begin
                if (inflight && !pop)        occ_next = OCC_TWO;
                else if (!inflight && pop)   occ_next = OCC_EMPTY;
            end
            OCC_TWO:   if (!inflight && pop) occ_next = OCC_ONE;
            default:                         occ_next = OCC_EMPTY;
        endcase
    end

    // Output buffer occupancy: outputs
    always_comb begin
        m_valid = (occ != OCC_EMPTY);
        m_data  = head_q;
    end

    // Buffer storage. On write-with-pop the incoming word lands behind
    // whatever remains, so ordering is kept in every case.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            head_q <= '0;
            tail_q <= '0;
        end else if (pop) begin
            if (occ == OCC_TWO) begin
                head_q <= tail_q;
                if (inflight) tail_q <= mem_rdata;
            end else if (inflight) begin
                head_q <= mem_rdata;
            end
        end else if (inflight) begin
            if (occ == OCC_EMPTY) head_q <= mem_rdata;
            else                  tail_q <= mem_rdata;
        end
    end

endmodule
